// File: rtl/funct_generator_pkg.sv
// funct_generator_pkg: FSM state encoding and default widths shared by the function generator.
package funct_generator_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ADDR_WIDTH = 8;
  localparam int DEF_PHASE_WIDTH = 16;
endpackage

// File: rtl/funct_generator_seq.sv
// funct_generator_seq: phase-accumulator LUT sequencer streaming samples into a FIFO with a 1-entry skid.
// Optional FUNCT_GEN_BURST_EN adds burst_len_i/done_o for fixed-length bursts.
module funct_generator_seq
  import funct_generator_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int PHASE_WIDTH = DEF_PHASE_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start_i,
  input  logic                   stop_i,
  input  logic [PHASE_WIDTH-1:0] freq_word_i,
  output logic [ADDR_WIDTH-1:0]  read_addr_o,
  input  logic [DATA_WIDTH-1:0]  read_data_i,
  input  logic                   fifo_full_i,
  output logic                   fifo_wr_en_o,
  output logic [DATA_WIDTH-1:0]  fifo_data_o,
  output logic                   busy_o
`ifdef FUNCT_GEN_BURST_EN
  ,
  input  logic [15:0]            burst_len_i,
  output logic                   done_o
`endif
);
  state_t state, state_n;
  logic [PHASE_WIDTH-1:0] phase, word;
  logic [DATA_WIDTH-1:0] skid;
  logic inflight, skid_valid, skid_valid_n;
  logic start_ok, issue, can_issue, last_issue, wr_skid, wr_direct, capture;
  // The address is presented straight from the accumulator so the LUT sees it in the issue cycle.
  assign read_addr_o = phase[PHASE_WIDTH-1 -: ADDR_WIDTH];
  assign busy_o = state != IDLE;
  assign start_ok = state == IDLE && start_i && !stop_i;
  assign issue = state == RUN && !stop_i && !fifo_full_i && !skid_valid && can_issue;
  assign wr_skid = skid_valid && !fifo_full_i;
  assign wr_direct = inflight && !skid_valid && !fifo_full_i;
  assign capture = inflight && !wr_direct;
  assign fifo_wr_en_o = wr_skid || wr_direct;
  assign fifo_data_o = skid_valid ? skid : read_data_i;
  assign skid_valid_n = capture || (skid_valid && !wr_skid);
  // Nothing issues in DRAIN, so only the skid can still hold data next cycle.
  always_comb begin
    state_n = state == IDLE ? (start_ok ? RUN : IDLE)
            : state == RUN ? (stop_i || (issue && last_issue) ? DRAIN : RUN)
            : (skid_valid_n ? DRAIN : IDLE);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      phase <= '0;
      word <= '0;
      inflight <= 1'b0;
      skid_valid <= 1'b0;
      skid <= '0;
    end else begin
      state <= state_n;
      inflight <= issue;
      skid_valid <= skid_valid_n;
      if (capture) skid <= read_data_i;
      if (start_ok) begin
        phase <= '0;
        word <= freq_word_i;
      end else if (issue) phase <= phase + word;
    end
  end
`ifdef FUNCT_GEN_BURST_EN
  logic [15:0] remaining;
  logic free;
  assign can_issue = free || remaining != 16'd0;
  assign last_issue = !free && remaining == 16'd1;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      remaining <= '0;
      free <= 1'b0;
      done_o <= 1'b0;
    end else begin
      done_o <= state == DRAIN && state_n == IDLE;
      if (start_ok) begin
        remaining <= burst_len_i;
        free <= burst_len_i == 16'd0;
      end else if (issue) remaining <= remaining - 16'd1;
    end
  end
`else
  assign can_issue = 1'b1;
  assign last_issue = 1'b0;
`endif
endmodule

// File: tb/tb_funct_generator_seq.sv
// tb_funct_generator_seq: randomized self-checking bench; expected samples come from phase = k*word arithmetic.
module tb_funct_generator_seq;
  localparam int DW = 32, AW = 8, PW = 16;
  logic clk = 1'b0, rst_n = 1'b0, start_i = 1'b0, stop_i = 1'b0, fifo_full_i = 1'b0;
  logic [PW-1:0] freq_word_i = '0;
  logic [AW-1:0] read_addr_o;
  logic [DW-1:0] read_data_i = '0, fifo_data_o;
  logic fifo_wr_en_o, busy_o;
  logic [DW-1:0] lut [2**AW];
  logic [DW-1:0] got [$];
  int got_cyc [$];
  int cyc = 0, checks = 0, errors = 0, full_wr = 0;
`ifdef FUNCT_GEN_BURST_EN
  logic [15:0] burst_len_i = '0;
  logic done_o;
  int dones = 0;
`endif

  funct_generator_seq dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .stop_i(stop_i),
    .freq_word_i(freq_word_i), .read_addr_o(read_addr_o), .read_data_i(read_data_i),
    .fifo_full_i(fifo_full_i), .fifo_wr_en_o(fifo_wr_en_o), .fifo_data_o(fifo_data_o),
    .busy_o(busy_o)
`ifdef FUNCT_GEN_BURST_EN
    , .burst_len_i(burst_len_i), .done_o(done_o)
`endif
  );

  always #5 clk = ~clk;

  // synchronous external LUT: data for an address appears one clock later
  always @(posedge clk) begin
    cyc <= cyc + 1;
    read_data_i <= lut[read_addr_o];
  end

  always @(negedge clk) begin
    if (fifo_wr_en_o) begin
      got.push_back(fifo_data_o);
      got_cyc.push_back(cyc);
      if (fifo_full_i) full_wr++;
    end
`ifdef FUNCT_GEN_BURST_EN
    if (done_o) dones++;
`endif
  end

  // k-th sample of a run reads the LUT at the top bits of (k*word mod 2**PW)
  function automatic logic [DW-1:0] exp_data(input logic [PW-1:0] w, input int k);
    longint ph;
    ph = (longint'(w) * longint'(k)) % (longint'(1) << PW);
    return lut[int'(ph >> (PW - AW))];
  endfunction

  task automatic do_start(input logic [PW-1:0] w, output int s);
    got.delete();
    got_cyc.delete();
    @(posedge clk); #1;
    freq_word_i = w;
    start_i = 1'b1;
    s = cyc;
    @(posedge clk); #1;
    start_i = 1'b0;
    freq_word_i = PW'($urandom());
  endtask

  // stays in RUN for len issuing cycles, poking start_i/freq_word_i which must be ignored
  task automatic run_stop(input int len);
    repeat (len) begin
      @(posedge clk); #1;
      start_i = 1'($urandom_range(0, 1));
      freq_word_i = PW'($urandom());
    end
    start_i = 1'b0;
    stop_i = 1'b1;
    @(posedge clk); #1;
    stop_i = 1'b0;
  endtask

  task automatic wait_idle(output int idle_cyc);
    idle_cyc = -1;
    for (int i = 0; i < 100 && idle_cyc < 0; i++) begin
      @(negedge clk);
      if (!busy_o) idle_cyc = cyc;
    end
    checks++;
    if (idle_cyc < 0) begin
      errors++;
      $display("FAIL idle_timeout busy_o stuck at %b, required 0", busy_o);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    checks += 3;
    if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy_o); end
    if (fifo_wr_en_o !== 1'b0) begin errors++; $display("FAIL reset_wr got %b exp 0", fifo_wr_en_o); end
    if (read_addr_o !== '0) begin errors++; $display("FAIL reset_addr got %h exp 0", read_addr_o); end
  endtask

  task automatic test_start_stop_same;
    @(posedge clk); #1;
    start_i = 1'b1;
    stop_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    stop_i = 1'b0;
    @(negedge clk);
    checks++;
    if (busy_o !== 1'b0) begin errors++; $display("FAIL start_with_stop busy got %b exp 0", busy_o); end
  endtask

  task automatic test_sweep(input string name, input logic [PW-1:0] w, input int len);
    int s, idle;
    do_start(w, s);
    @(negedge clk);
    checks++;
    if (busy_o !== 1'b1) begin errors++; $display("FAIL %s_busy got %b exp 1", name, busy_o); end
    run_stop(len - 1 + 1);
    wait_idle(idle);
    checks++;
    if (got.size() != len) begin errors++; $display("FAIL %s_count got %0d exp %0d", name, got.size(), len); end
    for (int k = 0; k < got.size() && k < len; k++) begin
      checks += 2;
      if (got[k] !== exp_data(w, k)) begin
        errors++;
        $display("FAIL %s_data[%0d] got %h exp %h", name, k, got[k], exp_data(w, k));
      end
      if (got_cyc[k] != s + 2 + k) begin
        errors++;
        $display("FAIL %s_timing[%0d] got cycle %0d exp %0d", name, k, got_cyc[k] - s, 2 + k);
      end
    end
    if (got.size() > 0) begin
      checks++;
      if (idle <= got_cyc[got.size()-1]) begin
        errors++;
        $display("FAIL %s_busy_fall got cycle %0d exp after %0d", name, idle, got_cyc[got.size()-1]);
      end
    end
  endtask

  task automatic test_wrap;
    logic [7:0] tbl [6] = '{8'h00, 8'hC0, 8'h80, 8'h40, 8'h00, 8'hC0};
    int s, idle;
    do_start(16'hC000, s);
    run_stop(6);
    wait_idle(idle);
    checks++;
    if (got.size() != 6) begin errors++; $display("FAIL wrap_count got %0d exp 6", got.size()); end
    for (int k = 0; k < got.size() && k < 6; k++) begin
      checks++;
      if (got[k][7:0] !== tbl[k]) begin errors++; $display("FAIL wrap_addr[%0d] got %h exp %h", k, got[k][7:0], tbl[k]); end
    end
  endtask

  task automatic test_backpressure;
    logic [PW-1:0] w;
    int s, idle;
    int exp_cyc [6] = '{7, 9, 10, 11, 12, 13};
    w = PW'($urandom());
    do_start(w, s);
    @(posedge clk); #1;
    fifo_full_i = 1'b1;
    repeat (5) @(posedge clk);
    #1 fifo_full_i = 1'b0;
    repeat (6) @(posedge clk);
    #1 stop_i = 1'b1;
    @(posedge clk); #1;
    stop_i = 1'b0;
    wait_idle(idle);
    checks += 2;
    if (got.size() != 6) begin errors++; $display("FAIL skid_count got %0d exp 6", got.size()); end
    if (full_wr != 0) begin errors++; $display("FAIL write_while_full got %0d exp 0", full_wr); end
    for (int k = 0; k < got.size() && k < 6; k++) begin
      checks += 2;
      if (got[k] !== exp_data(w, k)) begin errors++; $display("FAIL skid_data[%0d] got %h exp %h", k, got[k], exp_data(w, k)); end
      if (got_cyc[k] != s + exp_cyc[k]) begin
        errors++;
        $display("FAIL skid_timing[%0d] got cycle %0d exp %0d", k, got_cyc[k] - s, exp_cyc[k]);
      end
    end
  endtask

  task automatic test_reset_mid;
    int s;
    do_start(PW'($urandom()), s);
    @(posedge clk); #1;
    fifo_full_i = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    fifo_full_i = 1'b0;
    @(negedge clk);
    checks += 2;
    if (busy_o !== 1'b0) begin errors++; $display("FAIL rst_mid_busy got %b exp 0", busy_o); end
    if (fifo_wr_en_o !== 1'b0) begin errors++; $display("FAIL rst_mid_wr got %b exp 0", fifo_wr_en_o); end
    repeat (10) @(posedge clk);
    #1 checks++;
    if (got.size() != 0) begin errors++; $display("FAIL rst_mid_writes got %0d exp 0", got.size()); end
  endtask

`ifdef FUNCT_GEN_BURST_EN
  task automatic test_burst;
    logic [PW-1:0] w;
    int s, idle;
    w = PW'($urandom());
    dones = 0;
    burst_len_i = 16'd4;
    do_start(w, s);
    burst_len_i = 16'd0;
    wait_idle(idle);
    repeat (3) @(negedge clk);
    checks += 2;
    if (got.size() != 4) begin errors++; $display("FAIL burst_count got %0d exp 4", got.size()); end
    if (dones != 1) begin errors++; $display("FAIL burst_done_pulses got %0d exp 1", dones); end
    for (int k = 0; k < got.size() && k < 4; k++) begin
      checks++;
      if (got[k] !== exp_data(w, k)) begin errors++; $display("FAIL burst_data[%0d] got %h exp %h", k, got[k], exp_data(w, k)); end
    end
  endtask
`endif

  initial begin
    logic [31:0] r;
    for (int i = 0; i < 2**AW; i++) begin
      r = $urandom();
      lut[i] = {r[23:0], 8'(i)};
    end
    test_reset();
    test_start_stop_same();
    test_sweep("sweep", 16'h0100, 20);
    test_wrap();
    test_sweep("stop3", PW'($urandom()), 2);
    for (int t = 0; t < 4; t++) test_sweep("random", PW'($urandom()), $urandom_range(1, 24));
    test_backpressure();
    test_reset_mid();
`ifdef FUNCT_GEN_BURST_EN
    test_burst();
`endif
    checks++;
    if (full_wr != 0) begin errors++; $display("FAIL write_while_full_total got %0d exp 0", full_wr); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/funct_generator_seq.md
FUNCT_GENERATOR_SEQ -- requirements
Module: funct_generator_seq

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning LUT sample width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 8, meaning LUT address width (2**ADDR_WIDTH entries).
REQ-003 SHALL have parameter PHASE_WIDTH, default 16, meaning phase accumulator width; PHASE_WIDTH >= ADDR_WIDTH.
REQ-004 SHALL have port clk, input, 1, the single clock.
REQ-005 SHALL have port rst_n, input, 1, synchronous active-low reset.
REQ-006 SHALL have port start_i, input, 1, start request pulse.
REQ-007 SHALL have port stop_i, input, 1, stop request pulse.
REQ-008 SHALL have port freq_word_i, input, PHASE_WIDTH, the phase increment per sample.
REQ-009 SHALL have port read_addr_o, output, ADDR_WIDTH, the LUT read address.
REQ-010 SHALL have port read_data_i, input, DATA_WIDTH, the LUT data, valid 1 clk after its address.
REQ-011 SHALL have port fifo_full_i, input, 1, downstream FIFO full.
REQ-012 SHALL have port fifo_wr_en_o, output, 1, FIFO write strobe.
REQ-013 SHALL have port fifo_data_o, output, DATA_WIDTH, FIFO write data.
REQ-014 SHALL have port busy_o, output, 1, high whenever state != IDLE.

Function
REQ-015 SHALL implement FSM states IDLE, RUN, DRAIN.
REQ-016 In IDLE, start_i=1 with stop_i=0 SHALL clear the phase accumulator, latch freq_word_i, and enter RUN next clk; start_i with stop_i in the same cycle SHALL keep IDLE.
REQ-017 In RUN, a read SHALL issue in each cycle where fifo_full_i=0 and the skid register is empty; issuing sets read_addr_o = phase[PHASE_WIDTH-1 -: ADDR_WIDTH] and then phase <= phase + latched word, modulo 2**PHASE_WIDTH (silent wrap).
REQ-018 The first issued address after start SHALL be 0.
REQ-019 A returning sample (1 clk after issue) SHALL drive fifo_wr_en_o=1 and fifo_data_o=read_data_i in that cycle if fifo_full_i=0 and the skid register is empty; otherwise it SHALL be captured in a 1-entry skid register.
REQ-020 A skid entry SHALL be written (fifo_wr_en_o=1, fifo_data_o=skid) in the first cycle with fifo_full_i=0, taking priority; no issue SHALL occur while the skid register is occupied, so no sample is ever lost or reordered.
REQ-021 fifo_wr_en_o SHALL never be 1 while fifo_full_i=1.
REQ-022 start_i SHALL be ignored in RUN and DRAIN; freq_word_i changes SHALL take effect only at the next start.
REQ-023 stop_i in RUN SHALL stop issuing from that cycle and enter DRAIN; DRAIN SHALL return to IDLE once no read is in flight and the skid register is empty.

Reset
REQ-024 rst_n=0 at a clk edge SHALL force IDLE, phase=0, skid empty, in-flight flag clear, read_addr_o=0, busy_o=0; fifo_wr_en_o SHALL be 0 (and done_o=0 when configured) in the cycle following the reset edge, and in-flight data SHALL be discarded.

Configuration
REQ-025 Macro FUNCT_GEN_BURST_EN SHALL add input burst_len_i [15:0] (latched at start) and output done_o.
REQ-026 With FUNCT_GEN_BURST_EN, RUN SHALL issue exactly burst_len_i reads, then enter DRAIN; done_o SHALL pulse 1 clk on the DRAIN->IDLE transition (also after a stop-initiated drain); burst_len_i=0 SHALL mean free-running.
REQ-027 Without FUNCT_GEN_BURST_EN, the ports SHALL be absent and RUN SHALL continue until stop_i.

Structure
REQ-028 A package funct_generator_pkg SHALL hold the FSM state enum and default width constants.
REQ-029 The block SHALL be a single module with no sub-modules; the LUT stays external.

Verification
REQ-030 Verification SHALL cover: word=0x0100, ADDR=8, PHASE=16, FIFO never full -> addresses 0,1,2,... one per clk, first write 2 clk after start.
REQ-031 Verification SHALL cover: word=0xC000, run 6 samples -> addresses 0x00,0xC0,0x80,0x40,0x00,0xC0 (wrap).
REQ-032 Verification SHALL cover: fifo_full_i raised the cycle after an issue, held 5 clk -> sample held in skid, written first cycle full drops, no duplicates or loss, write order preserved.
REQ-033 Verification SHALL cover: stop_i 3 clk after start -> exactly the issued reads are written, busy_o falls after the last write.
REQ-034 Verification SHALL cover: rst_n=0 mid-RUN with a sample in skid -> next cycle busy_o=0, fifo_wr_en_o=0, no later write.
REQ-035 Verification SHALL cover, with FUNCT_GEN_BURST_EN and burst_len_i=4: exactly 4 writes, done_o single pulse, return to IDLE.
